mul_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one pipelined fixed-point multiplier (Q-format, `BITSIZE`-bit signed operands, rounded `2*BITSIZE-FRAC_BITS`-bit result, `start_flag`/`valid` handshake) among `NUM_REQ` requesters in the MobileNetV3 accelerator datapath. It selects at most one operand pair per cycle and drives the multiplier inputs. It carries a requester tag through a shift pipeline matched to the multiplier latency. It routes each result back to the requester that issued it, and flags a sticky error if multiplier `valid` and the tag pipeline disagree.

---
 rtl/mul_rr_arbiter.sv | 135 +++++++++++++
 tb/tb_mul_rr_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter sharing one pipelined fixed-point multiplier among
// NUM_REQ requesters. A requester tag rides a shift pipeline matched to the
// multiplier latency so each result is strobed back to its issuer.
// Optional feature: define MUL_ARB_BURST_EN to add req_lock_i, which lets the
// granted requester keep priority for back-to-back grants.
module mul_rr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BITSIZE   = 14,
    parameter int FRAC_BITS = 7,
    parameter int MUL_LAT   = 1
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [NUM_REQ-1:0]                 req_i,
    input  logic [NUM_REQ*BITSIZE-1:0]         req_a_i,
    input  logic [NUM_REQ*BITSIZE-1:0]         req_b_i,
`ifdef MUL_ARB_BURST_EN
    input  logic [NUM_REQ-1:0]                 req_lock_i,
`endif
    output logic [NUM_REQ-1:0]                 gnt_o,
    output logic [BITSIZE-1:0]                 mul_a_o,
    output logic [BITSIZE-1:0]                 mul_b_o,
    output logic                               mul_start_o,
    input  logic [2*BITSIZE-FRAC_BITS-1:0]     mul_result_i,
    input  logic                               mul_valid_i,
    output logic [NUM_REQ-1:0]                 rsp_valid_o,
    output logic [2*BITSIZE-FRAC_BITS-1:0]     rsp_data_o,
    output logic                               busy_o,
    output logic                               err_o
);

    localparam int IDXW = $clog2(NUM_REQ);

    logic [IDXW-1:0]               ptr_q, ptr_d;
    logic                          gnt_any;
    logic [IDXW-1:0]               gnt_idx;
    logic [IDXW-1:0]               cand;
    logic [MUL_LAT-1:0]            vld_q, vld_d;
    logic [MUL_LAT-1:0][IDXW-1:0]  idx_q, idx_d;
    logic                          err_q, err_d;
    logic                          last_vld;
    logic [IDXW-1:0]               last_idx;

    // Search for the first asserted request starting at the pointer, wrapping.
    // The grant is suppressed while reset is held so outputs are quiet.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDXW'((int'(ptr_q) + k) % NUM_REQ);
            if (!gnt_any && req_i[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (!rst_ni) begin
            gnt_any = 1'b0;
        end
    end

    // Grant vector and operand mux; operands read zero when nothing is granted.
    always_comb begin
        gnt_o       = '0;
        mul_a_o     = '0;
        mul_b_o     = '0;
        mul_start_o = gnt_any;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt_any && gnt_idx == IDXW'(k)) begin
                gnt_o[k] = 1'b1;
                mul_a_o  = req_a_i[k*BITSIZE +: BITSIZE];
                mul_b_o  = req_b_i[k*BITSIZE +: BITSIZE];
            end
        end
    end

    // Pointer moves past the winner; a locked burst pins it on the winner.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            if (gnt_idx == IDXW'(NUM_REQ-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
`ifdef MUL_ARB_BURST_EN
            if (req_lock_i[gnt_idx]) begin
                ptr_d = gnt_idx;
            end
`endif
        end
    end

    // Tag shift pipeline (no stall) and sticky valid/tag disagreement flag.
    always_comb begin
        vld_d    = '0;
        idx_d    = '0;
        vld_d[0] = gnt_any;
        idx_d[0] = gnt_idx;
        for (int s = 1; s < MUL_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            idx_d[s] = idx_q[s-1];
        end
        last_vld = vld_q[MUL_LAT-1];
        last_idx = idx_q[MUL_LAT-1];
        err_d    = err_q | (mul_valid_i ^ last_vld);
    end

    // Response routing; a mismatch never produces a strobe.
    always_comb begin
        rsp_valid_o = '0;
        if (mul_valid_i && last_vld) begin
            rsp_valid_o = NUM_REQ'(1) << last_idx;
        end
        rsp_data_o = mul_result_i;
        busy_o     = |vld_q;
        err_o      = err_q;
    end

    // State registers; reset discards every in-flight tag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            vld_q <= '0;
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            vld_q <= vld_d;
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Randomized bench for mul_rr_arbiter with an in-bench multiplier and a
// behavioural reference model checked on every falling edge.
module tb_mul_rr_arbiter;

    localparam int N  = 4;
    localparam int BW = 14;
    localparam int RW = 21;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req;
    logic [BW-1:0]   opa [N];
    logic [BW-1:0]   opb [N];
    logic [N*BW-1:0] req_a, req_b;
`ifdef MUL_ARB_BURST_EN
    logic [N-1:0]    lock;
`endif
    logic [N-1:0]    gnt, rsp_valid;
    logic [BW-1:0]   mul_a, mul_b;
    logic            mul_start, mul_valid, busy, err;
    logic [RW-1:0]   mul_result, rsp_data;
    logic            mv_q, force_v;
    logic [RW-1:0]   mres_q;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    int            m_ptr;
    bit            pend_v;
    int            pend_idx;
    logic [RW-1:0] pend_data;
    bit            m_err;

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int k = 0; k < N; k++) begin
            req_a[k*BW +: BW] = opa[k];
            req_b[k*BW +: BW] = opb[k];
        end
    end

    mul_rr_arbiter #(.NUM_REQ(N), .BITSIZE(BW), .FRAC_BITS(7), .MUL_LAT(1)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
`ifdef MUL_ARB_BURST_EN
        .req_lock_i   (lock),
`endif
        .gnt_o        (gnt),
        .mul_a_o      (mul_a),
        .mul_b_o      (mul_b),
        .mul_start_o  (mul_start),
        .mul_result_i (mul_result),
        .mul_valid_i  (mul_valid),
        .rsp_valid_o  (rsp_valid),
        .rsp_data_o   (rsp_data),
        .busy_o       (busy),
        .err_o        (err)
    );

    function automatic logic [RW-1:0] rnd(input logic [BW-1:0] a, input logic [BW-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        p = (p + 64) >>> 7;
        return p[RW-1:0];
    endfunction

    // one-cycle multiplier sharing the arbiter reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_q   <= 1'b0;
            mres_q <= '0;
        end else begin
            mv_q   <= mul_start;
            mres_q <= rnd(mul_a, mul_b);
        end
    end
    assign mul_valid  = mv_q | force_v;
    assign mul_result = mres_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // compare process: check DUT against the model, then advance the model
    always @(negedge clk) begin
        int e;
        int ii;
        bit mv;
        logic [N-1:0] eg, erv;
        if (!rst_n) begin
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_start", 32'(mul_start), 0);
            chk("rst_ops", 32'({mul_a, mul_b}), 0);
            chk("rst_rsp", 32'(rsp_valid), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_err", 32'(err), 0);
            m_ptr  = 0;
            pend_v = 0;
            m_err  = 0;
        end else begin
            e = -1;
            for (int k = 0; k < N; k++) begin
                ii = (m_ptr + k) % N;
                if (e < 0 && req[ii]) e = ii;
            end
            eg = (e >= 0) ? N'(1) << e : '0;
            mv = pend_v | force_v;
            chk("gnt", 32'(gnt), 32'(eg));
            chk("mul_start", 32'(mul_start), 32'(e >= 0));
            chk("mul_a", 32'(mul_a), (e >= 0) ? 32'(opa[e]) : 0);
            chk("mul_b", 32'(mul_b), (e >= 0) ? 32'(opb[e]) : 0);
            erv = (pend_v && mv) ? N'(1) << pend_idx : '0;
            chk("rsp_valid", 32'(rsp_valid), 32'(erv));
            if (erv != 0) chk("rsp_data", 32'(rsp_data), 32'(pend_data));
            chk("busy", 32'(busy), 32'(pend_v));
            chk("err", 32'(err), 32'(m_err));
            if (mv != pend_v) m_err = 1;
            pend_v = (e >= 0);
            if (e >= 0) begin
                pend_idx  = e;
                pend_data = rnd(opa[e], opb[e]);
                m_ptr     = (e + 1) % N;
`ifdef MUL_ARB_BURST_EN
                if (lock[e]) m_ptr = e;
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        req   = '0;
`ifdef MUL_ARB_BURST_EN
        lock  = '0;
`endif
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_b [4];
        rst_n   = 1'b0;
        req     = 4'hF;
        force_v = 1'b0;
`ifdef MUL_ARB_BURST_EN
        lock    = '0;
`endif
        for (int k = 0; k < N; k++) begin
            opa[k] = '0;
            opb[k] = '0;
        end
        repeat (3) step();
        #2 chk("lit_rst_gnt", 32'(gnt), 0);
        step();
        rst_n = 1'b1;
        req   = '0;
        step();

        // single requester: 1.5 * 2.0 = 3.0
        req = 4'b0100; opa[2] = 14'd192; opb[2] = 14'd256;
        #2 chk("lit_single_gnt", 32'(gnt), 32'h4);
        chk("lit_single_busy0", 32'(busy), 0);
        step();
        req = '0;
        #2 chk("lit_single_rsp", 32'(rsp_valid), 32'h4);
        chk("lit_single_data", 32'(rsp_data), 384);
        chk("lit_single_busy1", 32'(busy), 1);
        step();
        #2 chk("lit_single_busy2", 32'(busy), 0);

        // fairness from pointer 0
        do_reset();
        for (int c = 0; c < 8; c++) begin
            req = 4'hF;
            for (int k = 0; k < N; k++) begin
                opa[k] = BW'($urandom);
                opb[k] = BW'($urandom);
            end
            #2 chk("lit_fair_gnt", 32'(gnt), 32'(1) << (c % 4));
            if (c > 0) chk("lit_fair_rsp", 32'(rsp_valid), 32'(1) << ((c - 1) % 4));
            step();
        end
        req = '0;
        #2 chk("lit_fair_rsp_last", 32'(rsp_valid), 32'h8);
        step();

        // burst hold (pointer is 0 here)
`ifdef MUL_ARB_BURST_EN
        exp_b = '{1, 1, 1, 3};
`else
        exp_b = '{1, 3, 1, 3};
`endif
        for (int c = 0; c < 4; c++) begin
            req = (c < 3) ? 4'b1010 : 4'b1000;
`ifdef MUL_ARB_BURST_EN
            lock = (c < 3) ? 4'b0010 : 4'b0000;
`endif
            #2 chk("lit_burst_gnt", 32'(gnt), 32'(1) << exp_b[c]);
            step();
        end
        req = '0;
`ifdef MUL_ARB_BURST_EN
        lock = '0;
`endif
        step();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            req = N'($urandom_range(0, 15));
`ifdef MUL_ARB_BURST_EN
            lock = N'($urandom_range(0, 15));
`endif
            for (int k = 0; k < N; k++) begin
                opa[k] = BW'($urandom);
                opb[k] = BW'($urandom);
            end
            step();
        end
        req = '0;
`ifdef MUL_ARB_BURST_EN
        lock = '0;
`endif
        step();
        step();

        // reset while requester 1's result is in flight
        req = 4'b0010;
        #2 chk("lit_mid_gnt", 32'(gnt), 32'h2);
        step();
        rst_n = 1'b0;
        req   = '0;
        #2 chk("lit_mid_rsp", 32'(rsp_valid), 0);
        chk("lit_mid_busy", 32'(busy), 0);
        step();
        rst_n = 1'b1;
        req   = 4'hF;
        #2 chk("lit_mid_first", 32'(gnt), 32'h1);
        step();
        req = '0;
        step();
        step();

        // spurious multiplier valid
        force_v = 1'b1;
        #2 chk("lit_err_pre", 32'(err), 0);
        chk("lit_err_rsp0", 32'(rsp_valid), 0);
        step();
        force_v = 1'b0;
        #2 chk("lit_err_set", 32'(err), 1);
        chk("lit_err_rsp1", 32'(rsp_valid), 0);
        repeat (3) step();
        chk("lit_err_sticky", 32'(err), 1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
